button_debouncer: RTL and testbench

Per-channel push-button conditioner between the board's raw active-low KEY inputs and the BCD counter / display logic. It synchronizes each button and filters contact bounce with a stability counter. It emits a clean debounced level plus single-cycle press, release and auto-repeat strobes. The BCD counter's count-enable is driven from the press strobe of channel 0, so one physical push advances the count by exactly one.

---
 rtl/button_debouncer_if.sv | 35 +++
 rtl/button_debouncer.sv | 166 ++++++++++++++++
 tb/tb_button_debouncer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : button_debouncer_if
// Brief   : Raw button inputs and conditioned level/strobe outputs.
// Rev     : 1.0
// ============================================================================

interface button_debouncer_if #(
  parameter int unsigned P_CH = 2
);
  logic [P_CH-1:0] btn_n;
  logic [P_CH-1:0] level;
  logic [P_CH-1:0] press_pulse;
  logic [P_CH-1:0] release_pulse;
  logic [P_CH-1:0] repeat_pulse;

  modport master (
    output btn_n,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  btn_n,
    output level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Brief   : Per-channel button synchronizer, debouncer and auto-repeat strober.
// Rev     : 1.0
// ============================================================================

module button_debouncer #(
  parameter int unsigned P_CH              = 2,
  parameter int unsigned P_DEBOUNCE_CYCLES = 50000,
  parameter int unsigned P_REPEAT_DELAY    = 25000000,
  parameter int unsigned P_REPEAT_PERIOD   = 5000000
) (
  input wire                clk_i,
  input wire                rst_ni,
  button_debouncer_if.slave bus
);

  localparam int unsigned c_deb_w   = $clog2(P_DEBOUNCE_CYCLES);
  localparam int unsigned c_rpt_max = (P_REPEAT_DELAY > P_REPEAT_PERIOD) ?
                                      P_REPEAT_DELAY : P_REPEAT_PERIOD;
  localparam int unsigned c_rpt_w   = $clog2(c_rpt_max + 1);
  localparam bit          c_rpt_en  = (P_REPEAT_DELAY != 0);

  localparam logic [c_deb_w-1:0] c_deb_last    = c_deb_w'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(P_REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(P_REPEAT_PERIOD - 1);
  localparam logic [c_rpt_w-1:0] c_rpt_top     = c_rpt_w'(c_rpt_max);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [P_CH-1:0] sync1_q;
  logic [P_CH-1:0] sync2_q;

  // Reset to 1 so a button held through reset still needs a full debounce.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar g = 0; g < int'(P_CH); g++) begin : g_ch
      logic               pressed_s;
      logic [1:0]         state_q, state_d;
      logic [c_deb_w-1:0] deb_q, deb_d;
      logic [c_rpt_w-1:0] rpt_q, rpt_d;
      logic               first_q, first_d;
      logic               rpt_fire;
      logic               held_q, held_d;
      logic               level_q, level_d;
      logic               press_q, press_d;
      logic               release_q, release_d;
      logic               repeat_q, repeat_d;

      assign pressed_s = ~sync2_q[g];
      assign held_q    = (state_q == S_PRESSED) || (state_q == S_RELEASE_WAIT);
      assign held_d    = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q   <= S_RELEASED;
          deb_q     <= '0;
          rpt_q     <= '0;
          first_q   <= 1'b1;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
        end else begin
          state_q   <= state_d;
          deb_q     <= deb_d;
          rpt_q     <= rpt_d;
          first_q   <= first_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          repeat_q  <= repeat_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        deb_d    = deb_q;
        rpt_d    = rpt_q;
        first_d  = first_q;
        rpt_fire = 1'b0;

        case (state_q)
          S_RELEASED: begin
            deb_d = '0;
            if (pressed_s) state_d = S_PRESS_WAIT;
          end
          S_PRESS_WAIT: begin
            if (!pressed_s) begin
              state_d = S_RELEASED;
              deb_d   = '0;
            end else if (deb_q == c_deb_last) begin
              state_d = S_PRESSED;
              deb_d   = '0;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end
          S_PRESSED: begin
            deb_d = '0;
            if (!pressed_s) state_d = S_RELEASE_WAIT;
          end
          S_RELEASE_WAIT: begin
            if (pressed_s) begin
              state_d = S_PRESSED;
              deb_d   = '0;
            end else if (deb_q == c_deb_last) begin
              state_d = S_RELEASED;
              deb_d   = '0;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end
          default: begin
            state_d = S_RELEASED;
            deb_d   = '0;
          end
        endcase

        // Repeat timer runs only across consecutive held cycles; leaving
        // the held region (release acceptance) clears it without firing.
        if (!held_d || !held_q) begin
          rpt_d   = '0;
          first_d = 1'b1;
        end else if (c_rpt_en) begin
          if (rpt_q == (first_q ? c_delay_last : c_period_last)) begin
            rpt_d    = '0;
            first_d  = 1'b0;
            rpt_fire = 1'b1;
          end else if (rpt_q != c_rpt_top) begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end

      always_comb begin
        level_d   = held_d;
        press_d   = (state_q == S_PRESS_WAIT)   && (state_d == S_PRESSED);
        release_d = (state_q == S_RELEASE_WAIT) && (state_d == S_RELEASED);
        repeat_d  = rpt_fire;
      end

      assign bus.level[g]         = level_q;
      assign bus.press_pulse[g]   = press_q;
      assign bus.release_pulse[g] = release_q;
      assign bus.repeat_pulse[g]  = repeat_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_button_debouncer
// Brief   : Scoreboard bench for button_debouncer (N=8, delay=40, period=10).
// Rev     : 1.0
// ============================================================================

module tb_button_debouncer;

  localparam int unsigned P_CH  = 2;
  localparam int unsigned P_DEB = 8;
  localparam int unsigned P_DLY = 40;
  localparam int unsigned P_PER = 10;
  localparam int          LAT   = 2 + P_DEB + 1;  // drive negedge -> strobe-cycle negedge

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_press [P_CH];
  int   n_release [P_CH];
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic mon_v;

  button_debouncer_if #(.P_CH(P_CH)) bus ();

  button_debouncer #(
    .P_CH              (P_CH),
    .P_DEBOUNCE_CYCLES (P_DEB),
    .P_REPEAT_DELAY    (P_DLY),
    .P_REPEAT_PERIOD   (P_PER)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    return (k == K_PRESS) ? "press" : (k == K_RELEASE) ? "release" : "repeat";
  endfunction

  function automatic void push_ev(input int c, input int k, input int ch);
    ev_t e;
    e.cyc = c; e.kind = k; e.ch = ch;
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard: every observed strobe must match the head of the expected queue.
  always @(negedge clk) begin
    for (int ch = 0; ch < int'(P_CH); ch++) begin
      for (int k = 0; k < 3; k++) begin
        mon_v = (k == K_PRESS) ? bus.press_pulse[ch] :
                (k == K_RELEASE) ? bus.release_pulse[ch] : bus.repeat_pulse[ch];
        if (mon_v === 1'b1) begin
          if (k == K_PRESS)   n_press[ch]++;
          if (k == K_RELEASE) n_release[ch]++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: got %s ch=%0d cyc=%0d, expected no strobe",
                     kname(k), ch, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc !== cyc || mon_e.kind !== k || mon_e.ch !== ch) begin
              errors++;
              $display("FAIL strobe: got %s ch=%0d cyc=%0d, expected %s ch=%0d cyc=%0d",
                       kname(k), ch, cyc, kname(mon_e.kind), mon_e.ch, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.btn_n = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {bus.level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (bus.level !== 2'b00) begin
      errors++;
      $display("FAIL idle_level: got %b, expected 00", bus.level);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_missing: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clean_press();
    int c0;
    @(negedge clk);
    c0 = cyc;
    bus.btn_n[0] = 1'b0;
    push_ev(c0 + LAT, K_PRESS, 0);
    wait_until(c0 + LAT - 1);
    checks++;
    if (bus.level !== 2'b00) begin
      errors++;
      $display("FAIL press_early: got level=%b, expected 00", bus.level);
    end
    wait_until(c0 + LAT);
    checks++;
    if (bus.level !== 2'b01 || bus.press_pulse !== 2'b01) begin
      errors++;
      $display("FAIL press_edge: got level=%b press=%b, expected 01/01",
               bus.level, bus.press_pulse);
    end
    @(negedge clk);
    checks++;
    if (bus.press_pulse !== 2'b00 || bus.level !== 2'b01) begin
      errors++;
      $display("FAIL press_width: got level=%b press=%b, expected 01/00",
               bus.level, bus.press_pulse);
    end
    c0 = cyc;
    bus.btn_n[0] = 1'b1;
    push_ev(c0 + LAT, K_RELEASE, 0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.level !== 2'b00) begin
      errors++;
      $display("FAIL clean_release: got pending=%0d level=%b, expected 0/00",
               exp_q.size(), bus.level);
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 48) t = cyc;
      bus.btn_n[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
    end
    push_ev(t + LAT, K_PRESS, 0);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.level !== 2'b01) begin
      errors++;
      $display("FAIL bounce_press: got pending=%0d level=%b, expected 0/01",
               exp_q.size(), bus.level);
      exp_q.delete();
    end
    bus.btn_n[0] = 1'b1;
    push_ev(cyc + LAT, K_RELEASE, 0);
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_release: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_repeat();
    int pc;
    int rc;
    @(negedge clk);
    pc = cyc + LAT;
    rc = pc + 80 + LAT;
    bus.btn_n[0] = 1'b0;
    push_ev(pc, K_PRESS, 0);
    for (int t = pc + int'(P_DLY); t < rc; t += int'(P_PER)) push_ev(t, K_REPEAT, 0);
    push_ev(rc, K_RELEASE, 0);
    wait_until(pc + 80);
    checks++;
    if (bus.level !== 2'b01) begin
      errors++;
      $display("FAIL repeat_hold_level: got %b, expected 01", bus.level);
    end
    bus.btn_n[0] = 1'b1;
    wait_until(rc - 1);
    checks++;
    if (bus.level !== 2'b01) begin
      errors++;
      $display("FAIL release_early: got level=%b, expected 01", bus.level);
    end
    wait_until(rc + 40);
    checks++;
    if (exp_q.size() != 0 || bus.level !== 2'b00) begin
      errors++;
      $display("FAIL repeat_seq: got pending=%0d level=%b, expected 0/00",
               exp_q.size(), bus.level);
      exp_q.delete();
    end
  endtask

  task automatic test_dual_reset();
    int c0;
    @(negedge clk);
    c0 = cyc;
    bus.btn_n = 2'b00;
    push_ev(c0 + LAT, K_PRESS, 0);
    push_ev(c0 + LAT, K_PRESS, 1);
    wait_until(c0 + LAT);
    checks++;
    if (bus.press_pulse !== 2'b11) begin
      errors++;
      $display("FAIL dual_press: got %b, expected 11", bus.press_pulse);
    end
    wait_until(c0 + 20);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.level !== 2'b00 || bus.press_pulse !== 2'b00 ||
        bus.release_pulse !== 2'b00 || bus.repeat_pulse !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got level=%b press=%b rel=%b rep=%b, expected all 00",
               bus.level, bus.press_pulse, bus.release_pulse, bus.repeat_pulse);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    push_ev(c0 + LAT, K_PRESS, 0);
    push_ev(c0 + LAT, K_PRESS, 1);
    wait_until(c0 + LAT);
    checks++;
    if (bus.level !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_press: got level=%b, expected 11", bus.level);
    end
    @(negedge clk);
    bus.btn_n = 2'b11;
    push_ev(cyc + LAT, K_RELEASE, 0);
    push_ev(cyc + LAT, K_RELEASE, 1);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL dual_release: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int p0 = n_press[0];
    int r0 = n_release[0];
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.btn_n[0] = 1'b0;
      push_ev(cyc + LAT, K_PRESS, 0);
      repeat (20) @(negedge clk);
      bus.btn_n[0] = 1'b1;
      push_ev(cyc + LAT, K_RELEASE, 0);
      repeat (20) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (n_press[0] - p0 !== 10) begin
      errors++;
      $display("FAIL b2b_press_count: got %0d, expected 10", n_press[0] - p0);
    end
    checks++;
    if (n_release[0] - r0 !== 10) begin
      errors++;
      $display("FAIL b2b_release_count: got %0d, expected 10", n_release[0] - r0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cyc=%0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(P_CH); i++) begin
      n_press[i]   = 0;
      n_release[i] = 0;
    end
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_dual_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
